// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// operation and state encodings, the default data bus width and small op decoders.
package hilo_muldiv_ctrl_pkg;

    localparam int DATA_BUS = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_SIGN = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } step_mode_e;

    function automatic logic op_is_div(input logic [1:0] op_code);
        return op_code[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op_code);
        return ~op_code[0];
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-side request/response bundle of the multiply/divide sequencer.
// The master is the EX stage; the slave is the sequencer.
interface hilo_muldiv_ctrl_if
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BUS
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] opa;
    logic [DATA_WIDTH-1:0] opb;
    logic                  flush;
    logic                  stall_req;
    logic                  hilo_write_en;
    logic [DATA_WIDTH-1:0] hi_o;
    logic [DATA_WIDTH-1:0] lo_o;

    modport master (
        output start, op, opa, opb, flush,
        input  stall_req, hilo_write_en, hi_o, lo_o
    );

    modport slave (
        input  start, op, opa, opb, flush,
        output stall_req, hilo_write_en, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv_ctrl_muldiv_step.sv
// One combinational iteration: right-shifting shift-add for multiply, or
// left-shifting restoring subtract for divide, on a {hi, lo} accumulator.
module muldiv_step
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BUS
) (
    input  step_mode_e              mode,
    input  logic [2*DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0]   operand,
    output logic [2*DATA_WIDTH-1:0] acc_next,
    output logic                    q_bit
);
    localparam int W = DATA_WIDTH;

    logic [W:0] sum_s;
    logic [W:0] rem_sh_s;
    logic [W:0] diff_s;

    // Single step; for divide the caller merges q_bit into the freed LSB.
    always_comb begin
        sum_s    = {1'b0, acc[2*W-1:W]} + {1'b0, operand};
        rem_sh_s = acc[2*W-1:W-1];
        diff_s   = rem_sh_s - {1'b0, operand};
        acc_next = '0;
        q_bit    = 1'b0;
        case (mode)
            MODE_MUL: begin
                if (acc[0]) begin
                    acc_next = {sum_s, acc[W-1:1]};
                end else begin
                    acc_next = {1'b0, acc[2*W-1:1]};
                end
            end
            MODE_DIV: begin
                if (rem_sh_s >= {1'b0, operand}) begin
                    acc_next = {diff_s[W-1:0], acc[W-2:0], 1'b0};
                    q_bit    = 1'b1;
                end else begin
                    acc_next = {rem_sh_s[W-1:0], acc[W-2:0], 1'b0};
                    q_bit    = 1'b0;
                end
            end
            default: begin
                acc_next = acc;
                q_bit    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer producing HI/LO write data; stalls
// EX while iterating and pulses hilo_write_en for one cycle with the result.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BUS
) (
    input logic               clk,
    input logic               rst_n,
    hilo_muldiv_ctrl_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

    state_e              state_r;
    state_e              state_nxt_s;
    logic [CW-1:0]       cnt_r;
    logic [2*W-1:0]      acc_r;
    logic [W-1:0]        operand_r;
    op_e                 op_r;
    logic                neg_res_r;
    logic                neg_rem_r;
    logic [W-1:0]        hi_r;
    logic [W-1:0]        lo_r;

    logic                accept_s;
    logic                sign_a_s;
    logic                sign_b_s;
    logic                busy_s;
    step_mode_e          step_mode_s;
    logic [2*W-1:0]      step_acc_s;
    logic                step_q_s;
    logic [2*W-1:0]      fix_s;
    logic [2*W-1:0]      result_s;

    function automatic logic [W-1:0] cneg(input logic [W-1:0] v, input logic neg);
        return neg ? ((~v) + W'(1)) : v;
    endfunction

    function automatic logic [2*W-1:0] cneg2(input logic [2*W-1:0] v, input logic neg);
        return neg ? ((~v) + (2*W)'(1)) : v;
    endfunction

    assign accept_s    = (state_r == ST_IDLE) && bus.start && !bus.flush;
    assign sign_a_s    = op_is_signed(bus.op) & bus.opa[W-1];
    assign sign_b_s    = op_is_signed(bus.op) & bus.opb[W-1];
    assign busy_s      = (state_r == ST_MUL) || (state_r == ST_DIV) || (state_r == ST_SIGN);
    assign step_mode_s = (state_r == ST_DIV) ? MODE_DIV : MODE_MUL;

    muldiv_step #(.DATA_WIDTH(W)) u_step (
        .mode     (step_mode_s),
        .acc      (acc_r),
        .operand  (operand_r),
        .acc_next (step_acc_s),
        .q_bit    (step_q_s)
    );

    // Stall is low in DONE so EX advances in the cycle it receives the result.
    assign bus.stall_req     = !bus.flush && (((state_r == ST_IDLE) && bus.start) || busy_s);
    assign bus.hilo_write_en = (state_r == ST_DONE) && !bus.flush;
    assign bus.hi_o          = hi_r;
    assign bus.lo_o          = lo_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (op_is_div(bus.op) && (bus.opb == '0)) begin
                        state_nxt_s = ST_DONE;
                    end else if (op_is_div(bus.op)) begin
                        state_nxt_s = ST_DIV;
                    end else begin
                        state_nxt_s = ST_MUL;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_r == LAST_STEP) begin
                    state_nxt_s = ST_SIGN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_SIGN: state_nxt_s = ST_DONE;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Operand capture on accept, then one iteration per MUL/DIV cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= '0;
            acc_r     <= '0;
            operand_r <= '0;
            op_r      <= OP_MULT;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r     <= '0;
            acc_r     <= {{W{1'b0}}, cneg(bus.opa, sign_a_s)};
            operand_r <= cneg(bus.opb, sign_b_s);
            op_r      <= op_e'(bus.op);
            neg_res_r <= sign_a_s ^ sign_b_s;
            neg_rem_r <= sign_a_s;
        end else if (((state_r == ST_MUL) || (state_r == ST_DIV)) && !bus.flush) begin
            cnt_r <= cnt_r + CW'(1);
            acc_r <= {step_acc_s[2*W-1:1], step_q_s | step_acc_s[0]};
        end
    end

    // Sign fix-up of magnitudes; remainder follows the dividend sign.
    always_comb begin
        fix_s = acc_r;
        if (op_is_div(op_r)) begin
            fix_s = {cneg(acc_r[2*W-1:W], neg_rem_r), cneg(acc_r[W-1:0], neg_res_r)};
        end else begin
            fix_s = cneg2(acc_r, neg_res_r);
        end
        if (state_r == ST_IDLE) begin
            result_s = {bus.opa, {W{1'b1}}};
        end else begin
            result_s = fix_s;
        end
    end

    // HI/LO result registers update only on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (state_nxt_s == ST_DONE) begin
            hi_r <= result_s[2*W-1:W];
            lo_r <= result_s[W-1:0];
        end
    end

endmodule
